sram_line_prefetcher: RTL and testbench
=======================================

Name: sram_line_prefetcher

Overview:
- Reader side of the SRAM frame store. The frame encoder writes pixel words into SRAM; this block reads one scanline of words back into a double-buffered on-chip line buffer.
- Fetches run during the previous line's display/blanking. The pixel pipeline reads from the front bank at 1-cycle latency, so the pixel path never waits on SRAM.
- Sits between the SRAM address/data mux and the frame decoder's colour lookup.
- Yields the SRAM to the writer whenever the writer holds the bus.

Parameters:
- LINE_WIDTH, 640, words per scanline / line-buffer depth per bank
- FRAME_LINES, 480, valid line indices 0..FRAME_LINES-1
- ADDR_WIDTH, 20, SRAM address width
- DATA_WIDTH, 16, SRAM word width
- BASE_ADDR, 0, SRAM word address of line 0, pixel 0

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_line_start  in  1  one-cycle pulse: swap banks, begin fetching line i_line_idx into new back bank
- i_line_idx  in  10  line to fetch, sampled with i_line_start
- i_sram_busy  in  1  writer owns SRAM this cycle (the writer's write-enable)
- o_sram_addr  out  ADDR_WIDTH  read address, valid when o_sram_read=1
- o_sram_read  out  1  read issued this cycle
- i_sram_data  in  DATA_WIDTH  SRAM read data; holds the word for the address issued in the previous cycle
- i_rd_x  in  10  pixel index into the front bank
- o_rd_data  out  DATA_WIDTH  front-bank word, registered
- o_fetch_busy  out  1  fetch in progress
- o_fetch_done  out  1  one-cycle pulse: back bank complete
- o_underrun  out  1  sticky: a line_start arrived before the fetch finished

Behaviour:
- Interface decided: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values:
  - FSM=IDLE; all outputs 0; front-bank select=0.
  - Bank RAM contents are not cleared.
  - Reset mid-fetch aborts the fetch immediately. No o_sram_read is asserted in the cycle after reset.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - i_line_start: toggle front select.
  - If i_line_idx<FRAME_LINES: load addr=BASE_ADDR+i_line_idx*LINE_WIDTH (truncated to ADDR_WIDTH), x_issue=0, go to FETCH.
  - Otherwise (vertical blank): no fetch; pulse o_fetch_done next cycle; stay in IDLE.
- FETCH:
  - Each cycle with i_sram_busy=0: o_sram_read=1, o_sram_addr=addr, then addr++ and x_issue++. Combinational from state/busy.
  - Cycle with i_sram_busy=1: o_sram_read=0; counters hold.
  - Capture: on the cycle after an issued read, write i_sram_data into back bank[x_capture], then x_capture++.
  - Captures are tracked with a pending flag, so a busy cycle never causes a write of stale data.
  - After issuing x=LINE_WIDTH-1, go to DRAIN.
- DRAIN: perform the final capture, pulse o_fetch_done, go to IDLE.
- o_fetch_busy=1 in FETCH and DRAIN.
- i_line_start while FETCH/DRAIN:
  - Set o_underrun (cleared only by reset).
  - Swap banks anyway and restart the fetch for the new line.
  - The in-flight capture is discarded.
- Read port:
  - o_rd_data <= front[i_rd_x] every cycle (1-cycle latency).
  - i_rd_x>=LINE_WIDTH gives 0.
  - A bank swap takes effect for reads issued in the cycle after i_line_start.
- Fetch length is LINE_WIDTH+1 cycles when SRAM is uncontended, plus one cycle per busy cycle.

Optional Feature:
- Macro: SRAM_LINE_PREFETCH_STATS_EN.
- With the macro: adds output o_stall_cycles (16 bits).
  - Counts i_sram_busy cycles seen in FETCH, saturating at 16'hFFFF.
  - Cleared at each accepted i_line_start.
  - Value of the completed fetch is held from o_fetch_done until the next line_start.
- Without the macro: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Add to sram_pkg: LINE_WIDTH, FRAME_LINES, BASE_ADDR defaults; the FSM state enum (PF_IDLE, PF_FETCH, PF_DRAIN); the line-index width constant.
- One sub-module: line_buffer_bank. It is a single-port-write/single-port-read RAM of LINE_WIDTH x DATA_WIDTH with a registered read, instantiated twice.

Test Plan:
1. Uncontended fetch (LINE_WIDTH=8, BASE_ADDR=0x100, SRAM model returns data=addr):
   - line_start with idx=3 -> o_sram_addr issues 0x118..0x11F on 8 consecutive cycles.
   - o_fetch_done pulses on cycle 9.
   - After the next line_start, reading x=0..7 returns 0x118..0x11F.
2. Contention: i_sram_busy high on issue cycles 2 and 5 -> no reads on those cycles; addresses stay gap-free and in order; done arrives on cycle 11; buffer contents match test 1. With STATS_EN, o_stall_cycles=2.
3. Vertical blank: line_start with idx=480 -> no o_sram_read; o_fetch_done one cycle later; banks still swap.
4. Underrun: second line_start 4 cycles into a fetch -> o_underrun=1 and stays set; new fetch restarts from the new line base; no write lands from the aborted capture.
5. Reset mid-FETCH: i_rst high for 1 cycle at issue 3 -> next cycle o_sram_read=0, o_fetch_busy=0, o_underrun=0; the next line_start fetches normally.
6. Read port bounds: i_rd_x=LINE_WIDTH -> o_rd_data=0 one cycle later. A read issued the same cycle as line_start returns the old front bank; a read issued the next cycle returns the new front bank.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM frame-store reader blocks.
// Holds the default line geometry, the line-index width and the
// line prefetcher FSM state type.
package sram_pkg;

  localparam int unsigned LINE_WIDTH_DEFAULT  = 640;
  localparam int unsigned FRAME_LINES_DEFAULT = 480;
  localparam int unsigned BASE_ADDR_DEFAULT   = 0;
  localparam int unsigned LINE_IDX_W          = 10;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_FETCH,
    PF_DRAIN
  } pf_state_e;

endpackage

// File: rtl/line_buffer_bank.sv
// One bank of the scanline buffer: Depth x Width RAM with one write port
// and one registered read port. Contents are never reset.
//
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index, data appears on rdata_o one cycle later
//   rdata_o  registered read data
module line_buffer_bank #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 16,
  localparam int unsigned Aw   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sram_line_prefetcher.sv
// Reader side of the SRAM frame store. On each i_line_start the two line
// buffer banks swap roles and one scanline of words is fetched from SRAM into
// the new back bank, yielding the bus whenever the writer holds it. The pixel
// pipeline reads the front bank with one cycle of latency.
//
// Optional feature (define SRAM_LINE_PREFETCH_STATS_EN): adds o_stall_cycles,
// the number of writer-busy cycles seen during the current/last fetch.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_line_start       pulse: swap banks, start fetching line i_line_idx
//   i_line_idx         line to fetch (>= FRAME_LINES means vertical blank)
//   i_sram_busy        writer owns SRAM this cycle
//   o_sram_addr        read address, valid with o_sram_read
//   o_sram_read        read issued this cycle
//   i_sram_data        data for the address issued the previous cycle
//   i_rd_x             pixel index into the front bank
//   o_rd_data          front-bank word, 1-cycle latency, 0 when out of range
//   o_fetch_busy       fetch in progress
//   o_fetch_done       pulse: back bank complete
//   o_underrun         sticky: line start arrived before fetch finished
//   o_stall_cycles     (stats build only) busy cycles seen in FETCH
module sram_line_prefetcher
  import sram_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = LINE_WIDTH_DEFAULT,
  parameter int unsigned FRAME_LINES = FRAME_LINES_DEFAULT,
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_line_start,
  input  logic [LINE_IDX_W-1:0] i_line_idx,
  input  logic                  i_sram_busy,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_read,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  input  logic [9:0]            i_rd_x,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_fetch_busy,
  output logic                  o_fetch_done,
  output logic                  o_underrun
`ifdef SRAM_LINE_PREFETCH_STATS_EN
  ,
  output logic [15:0]           o_stall_cycles
`endif
);

  localparam int unsigned Xw = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [Xw-1:0] XLast = Xw'(LINE_WIDTH - 1);

  pf_state_e             state_q, state_d;
  logic                  front_sel_q, front_sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [Xw-1:0]         x_issue_q, x_issue_d;
  logic [Xw-1:0]         x_cap_q, x_cap_d;
  logic                  cap_pend_q, cap_pend_d;
  logic                  blank_done_q, blank_done_d;
  logic                  underrun_q, underrun_d;
  logic                  rd_sel_q, rd_zero_q;

  logic                  issue;
  logic                  cap_we;
  logic                  line_valid;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [DATA_WIDTH-1:0] bank0_rdata, bank1_rdata;

  assign line_base  = ADDR_WIDTH'(BASE_ADDR)
                    + ADDR_WIDTH'(i_line_idx) * ADDR_WIDTH'(LINE_WIDTH);
  assign line_valid = 32'(i_line_idx) < FRAME_LINES;

  assign issue = (state_q == PF_FETCH) && !i_sram_busy;
  // A line start discards the in-flight capture: its target bank is about to
  // become the front bank.
  assign cap_we = cap_pend_q && !i_line_start;

  always_comb begin
    state_d      = state_q;
    front_sel_d  = front_sel_q;
    addr_d       = addr_q;
    x_issue_d    = x_issue_q;
    x_cap_d      = x_cap_q;
    cap_pend_d   = 1'b0;
    blank_done_d = 1'b0;
    underrun_d   = underrun_q;

    if (cap_we) begin
      x_cap_d = x_cap_q + Xw'(1);
    end

    case (state_q)
      PF_IDLE: ;
      PF_FETCH: begin
        if (issue) begin
          addr_d     = addr_q + ADDR_WIDTH'(1);
          x_issue_d  = x_issue_q + Xw'(1);
          cap_pend_d = 1'b1;
          if (x_issue_q == XLast) begin
            state_d = PF_DRAIN;
          end
        end
      end
      PF_DRAIN: state_d = PF_IDLE;
      default:  state_d = PF_IDLE;
    endcase

    // Line start overrides everything, including an unfinished fetch.
    if (i_line_start) begin
      front_sel_d = ~front_sel_q;
      cap_pend_d  = 1'b0;
      x_issue_d   = '0;
      x_cap_d     = '0;
      if (state_q != PF_IDLE) begin
        underrun_d = 1'b1;
      end
      if (line_valid) begin
        addr_d  = line_base;
        state_d = PF_FETCH;
      end else begin
        state_d      = PF_IDLE;
        blank_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= PF_IDLE;
      front_sel_q  <= 1'b0;
      addr_q       <= '0;
      x_issue_q    <= '0;
      x_cap_q      <= '0;
      cap_pend_q   <= 1'b0;
      blank_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
      rd_zero_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      addr_q       <= addr_d;
      x_issue_q    <= x_issue_d;
      x_cap_q      <= x_cap_d;
      cap_pend_q   <= cap_pend_d;
      blank_done_q <= blank_done_d;
      underrun_q   <= underrun_d;
      rd_sel_q     <= front_sel_q;
      rd_zero_q    <= 32'(i_rd_x) >= LINE_WIDTH;
    end
  end

  // front_sel_q = 0: bank0 is front, bank1 is being filled.
  line_buffer_bank #(
    .Depth(LINE_WIDTH),
    .Width(DATA_WIDTH)
  ) u_bank0 (
    .clk_i  (i_clk),
    .we_i   (cap_we && front_sel_q),
    .waddr_i(x_cap_q),
    .wdata_i(i_sram_data),
    .raddr_i(Xw'(i_rd_x)),
    .rdata_o(bank0_rdata)
  );

  line_buffer_bank #(
    .Depth(LINE_WIDTH),
    .Width(DATA_WIDTH)
  ) u_bank1 (
    .clk_i  (i_clk),
    .we_i   (cap_we && !front_sel_q),
    .waddr_i(x_cap_q),
    .wdata_i(i_sram_data),
    .raddr_i(Xw'(i_rd_x)),
    .rdata_o(bank1_rdata)
  );

  assign o_rd_data    = rd_zero_q ? '0 : (rd_sel_q ? bank1_rdata : bank0_rdata);
  assign o_sram_read  = issue;
  assign o_sram_addr  = issue ? addr_q : '0;
  assign o_fetch_busy = state_q != PF_IDLE;
  assign o_fetch_done = ((state_q == PF_DRAIN) && !i_line_start) || blank_done_q;
  assign o_underrun   = underrun_q;

`ifdef SRAM_LINE_PREFETCH_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == PF_FETCH) && i_sram_busy && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (i_line_start) begin
      stall_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sram_line_prefetcher.sv
// Self-checking bench for sram_line_prefetcher (LINE_WIDTH=8, BASE_ADDR=0x100).
// The reference model keeps the contents of the front and back line buffers as
// plain arrays and derives the expected read/address/done sequence of each
// fetch from the busy pattern the bench itself chooses.
module tb_sram_line_prefetcher;

  localparam int unsigned LW   = 8;
  localparam int unsigned FL   = 480;
  localparam int unsigned BASE = 32'h100;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_line_start;
  logic [9:0]  i_line_idx;
  logic        i_sram_busy;
  logic [19:0] o_sram_addr;
  logic        o_sram_read;
  logic [15:0] i_sram_data;
  logic [9:0]  i_rd_x;
  logic [15:0] o_rd_data;
  logic        o_fetch_busy;
  logic        o_fetch_done;
  logic        o_underrun;
`ifdef SRAM_LINE_PREFETCH_STATS_EN
  logic [15:0] o_stall_cycles;
`endif

  sram_line_prefetcher #(
    .LINE_WIDTH (LW),
    .FRAME_LINES(FL),
    .ADDR_WIDTH (20),
    .DATA_WIDTH (16),
    .BASE_ADDR  (BASE)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_line_start(i_line_start),
    .i_line_idx  (i_line_idx),
    .i_sram_busy (i_sram_busy),
    .o_sram_addr (o_sram_addr),
    .o_sram_read (o_sram_read),
    .i_sram_data (i_sram_data),
    .i_rd_x      (i_rd_x),
    .o_rd_data   (o_rd_data),
    .o_fetch_busy(o_fetch_busy),
    .o_fetch_done(o_fetch_done),
    .o_underrun  (o_underrun)
`ifdef SRAM_LINE_PREFETCH_STATS_EN
    ,
    .o_stall_cycles(o_stall_cycles)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] sram_word(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [19:0] line_base(input int idx);
    return 20'(BASE + idx * LW);
  endfunction

  // SRAM: data for an issued address appears the next cycle; otherwise junk.
  always @(posedge i_clk) begin
    i_sram_data <= o_sram_read ? sram_word(o_sram_addr) : 16'($urandom);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference line buffers.
  logic [15:0] front_m [LW];
  bit          front_k [LW];
  logic [15:0] back_m  [LW];
  bit          back_k  [LW];

  logic [15:0] rd_exp;
  bit          rd_known = 1'b0;
  int          rd_force = -1;

  task automatic swap_model();
    logic [15:0] t;
    bit          k;
    for (int x = 0; x < LW; x++) begin
      t = front_m[x]; front_m[x] = back_m[x]; back_m[x] = t;
      k = front_k[x]; front_k[x] = back_k[x]; back_k[x] = k;
    end
  endtask

  task automatic forget_model();
    for (int x = 0; x < LW; x++) begin
      front_k[x] = 1'b0;
      back_k[x]  = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, sample 1 time unit later.
  task automatic tick(input bit start, input int idx, input bit busy, input bit rst);
    int x;
    @(negedge i_clk);
    x = (rd_force >= 0) ? rd_force : int'($urandom_range(LW + 1));
    i_line_start = start;
    i_line_idx   = 10'(idx);
    i_sram_busy  = busy;
    i_rst        = rst;
    i_rd_x       = 10'(x);
    #1;
    if (rd_known) check_eq("rd_data", 32'(o_rd_data), 32'(rd_exp));
    if (rst || x >= LW) begin
      rd_exp   = '0;
      rd_known = 1'b1;
    end else begin
      rd_exp   = front_m[x];
      rd_known = front_k[x];
    end
  endtask

  task automatic start_line(input int idx);
    tick(1'b1, idx, 1'($urandom_range(1)), 1'b0);
    swap_model();
  endtask

  // Runs up to max_c cycles of a fetch of line idx; commits the back bank on done.
  task automatic run_fetch(input int idx, input logic [31:0] mask, input int pct,
                           input int max_c);
    int  issued = 0;
    int  stalls = 0;
    bit  done_seen = 1'b0;
    logic [19:0] base;
    base = line_base(idx);
    for (int c = 0; c < max_c && !done_seen; c++) begin
      bit busy, exp_read, exp_done;
      busy = (c < 32 && mask[c]) || (c < 100 && $urandom_range(99) < pct);
      tick(1'b0, 0, busy, 1'b0);
      exp_done = (issued == LW);
      exp_read = !exp_done && !busy;
      check_eq("sram_read", 32'(o_sram_read), 32'(exp_read));
      if (exp_read) check_eq("sram_addr", 32'(o_sram_addr), 32'(base) + issued);
      check_eq("fetch_done", 32'(o_fetch_done), 32'(exp_done));
      check_eq("fetch_busy", 32'(o_fetch_busy), 32'd1);
`ifdef SRAM_LINE_PREFETCH_STATS_EN
      if (exp_done) check_eq("stall_cycles", 32'(o_stall_cycles), stalls);
`endif
      if (busy && !exp_done) stalls++;
      if (exp_read) issued++;
      if (exp_done) done_seen = 1'b1;
    end
    if (done_seen) begin
      for (int x = 0; x < LW; x++) begin
        back_m[x] = sram_word(20'(base + x));
        back_k[x] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 0, 1'($urandom_range(1)), 1'b0);
      check_eq("idle_read", 32'(o_sram_read), 32'd0);
      check_eq("idle_busy", 32'(o_fetch_busy), 32'd0);
      check_eq("idle_done", 32'(o_fetch_done), 32'd0);
    end
  endtask

  task automatic vblank(input int idx);
    start_line(idx);
    tick(1'b0, 0, 1'($urandom_range(1)), 1'b0);
    check_eq("vb_read", 32'(o_sram_read), 32'd0);
    check_eq("vb_done", 32'(o_fetch_done), 32'd1);
    check_eq("vb_busy", 32'(o_fetch_busy), 32'd0);
`ifdef SRAM_LINE_PREFETCH_STATS_EN
    check_eq("vb_stall", 32'(o_stall_cycles), 32'd0);
`endif
  endtask

  task automatic sweep();
    for (int x = 0; x <= LW + 1; x++) begin
      rd_force = x;
      tick(1'b0, 0, 1'($urandom_range(1)), 1'b0);
    end
    rd_force = -1;
    tick(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_line_start = 1'b0; i_line_idx = '0; i_sram_busy = 1'b0; i_rd_x = '0;
    forget_model();
    tick(1'b0, 0, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b1);
    tick(1'b0, 0, 1'b0, 1'b0);
    check_eq("rst_read", 32'(o_sram_read), 32'd0);
    check_eq("rst_addr", 32'(o_sram_addr), 32'd0);
    check_eq("rst_busy", 32'(o_fetch_busy), 32'd0);
    check_eq("rst_done", 32'(o_fetch_done), 32'd0);
    check_eq("rst_underrun", 32'(o_underrun), 32'd0);
    check_eq("rst_rd_data", 32'(o_rd_data), 32'd0);

    // Uncontended fetch of line 3, then same line with busy on cycles 2 and 5.
    start_line(3);
    run_fetch(3, 32'h0, 0, 200);
    idle(2);
    start_line(3);
    run_fetch(3, 32'h12, 0, 200);
    idle(1);
    sweep();
    start_line(7);
    run_fetch(7, 32'h0, 30, 200);
    sweep();

    // Underrun: fill two known lines, then abort a third after 4 cycles.
    start_line(20);
    run_fetch(20, 32'h0, 0, 200);
    start_line(21);
    run_fetch(21, 32'h0, 0, 200);
    start_line(22);
    run_fetch(22, 32'h0, 0, 3);
    check_eq("pre_underrun", 32'(o_underrun), 32'd0);
    for (int x = 0; x < 2; x++) begin
      back_m[x] = sram_word(20'(line_base(22) + x));
      back_k[x] = 1'b1;
    end
    start_line(23);
    run_fetch(23, 32'h0, 20, 200);
    check_eq("underrun_set", 32'(o_underrun), 32'd1);
    sweep();

    // Vertical blank with a same-cycle and next-cycle read across the swap.
    rd_force = 3;
    vblank(FL);
    tick(1'b0, 0, 1'b0, 1'b0);
    rd_force = -1;
    sweep();
    vblank(1023);
    sweep();
    check_eq("underrun_sticky", 32'(o_underrun), 32'd1);

    // Reset during the fourth issue cycle.
    start_line(40);
    run_fetch(40, 32'h0, 0, 3);
    tick(1'b0, 0, 1'b0, 1'b1);
    forget_model();
    tick(1'b0, 0, 1'b0, 1'b0);
    check_eq("postrst_read", 32'(o_sram_read), 32'd0);
    check_eq("postrst_busy", 32'(o_fetch_busy), 32'd0);
    check_eq("postrst_underrun", 32'(o_underrun), 32'd0);
    check_eq("postrst_done", 32'(o_fetch_done), 32'd0);
    start_line(41);
    run_fetch(41, 32'h0, 0, 200);
    idle(1);
    start_line(42);
    run_fetch(42, 32'h0, 0, 200);
    sweep();

    // Randomized lines, contention and blanking.
    for (int i = 0; i < 10; i++) begin
      int idx;
      idle(int'($urandom_range(2)));
      if ($urandom_range(99) < 15) begin
        idx = FL + int'($urandom_range(1023 - FL));
        vblank(idx);
      end else begin
        idx = int'($urandom_range(FL - 1));
        start_line(idx);
        run_fetch(idx, 32'h0, int'($urandom_range(50)), 200);
      end
      if ($urandom_range(1) == 1) sweep();
    end
    check_eq("final_underrun", 32'(o_underrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
